mult_arbiter: RTL and testbench

Round-robin arbiter and sequencer that shares one 16x16 unsigned array multiplier (`mult`) among `NREQ` requesters. It accepts one operand pair at a time over a valid/ready handshake and gives the combinational multiplier a full clock cycle to settle. It then returns the registered 32-bit product, tagged with the requester ID, over a response handshake. It sits between the requesting datapath units and the single `mult` instance.

---
 rtl/mult_arb_pkg.sv | 5 +
 rtl/mult.sv | 9 +
 rtl/rr_pick.sv | 26 ++
 rtl/mult_arbiter.sv | 97 +++++++++
 tb/tb_mult_arbiter.sv | 286 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mult_arb_pkg.sv
// mult_arb_pkg: shared state encoding and operand width for the multiplier arbiter.
package mult_arb_pkg;
    typedef enum logic [1:0] {IDLE, CALC, RESP} state_t;
    localparam int MULT_W = 16;
endpackage

// File: rtl/mult.sv
// mult: combinational 16x16 unsigned array multiplier with split 32-bit product.
module mult (
    input  logic [15:0] a,
    input  logic [15:0] b,
    output logic [15:0] hi,
    output logic [15:0] lo
);
    assign {hi, lo} = a * b;
endmodule

// File: rtl/rr_pick.sv
// rr_pick: combinational round-robin picker; first valid requester at or after ptr wins.
module rr_pick #(
    parameter int NREQ = 2,
    parameter int IDW  = 1
) (
    input  logic [NREQ-1:0] req_valid,
    input  logic [IDW-1:0]  ptr,
    output logic [NREQ-1:0] grant,
    output logic [IDW-1:0]  id
);
    logic found;
    always_comb begin
        grant = '0;
        id    = '0;
        found = 1'b0;
        for (int k = 0; k < NREQ; k++) begin
            for (int j = 0; j < NREQ; j++) begin
                if (!found && j == (int'(ptr) + k) % NREQ && req_valid[j]) begin
                    found    = 1'b1;
                    grant[j] = 1'b1;
                    id       = IDW'(j);
                end
            end
        end
    end
endmodule

// File: rtl/mult_arbiter.sv
// mult_arbiter: round-robin sharing of one mult among NREQ requesters.
// Operands are registered before mult so the multiplier path is register-to-register.
module mult_arbiter
    import mult_arb_pkg::*;
#(
    parameter int NREQ = 2,
    parameter int IDW  = 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NREQ-1:0]        req_valid,
    output logic [NREQ-1:0]        req_ready,
    input  logic [MULT_W*NREQ-1:0] req_a,
    input  logic [MULT_W*NREQ-1:0] req_b,
    output logic                   resp_valid,
    input  logic                   resp_ready,
    output logic [IDW-1:0]         resp_id,
    output logic [MULT_W-1:0]      resp_hi,
    output logic [MULT_W-1:0]      resp_lo,
    output logic                   busy
);
    state_t state_q, state_d;
    logic [IDW-1:0] ptr_q, ptr_d, id_q, id_d, pick_id;
    logic [NREQ-1:0] grant;
    logic [MULT_W-1:0] a_q, a_d, b_q, b_d, hi_q, hi_d, lo_q, lo_d, m_hi, m_lo;
    logic valid_q, valid_d, busy_q, busy_d, take;

    rr_pick #(.NREQ(NREQ), .IDW(IDW)) u_pick (
        .req_valid(req_valid),
        .ptr      (ptr_q),
        .grant    (grant),
        .id       (pick_id)
    );

    mult u_mult (.a(a_q), .b(b_q), .hi(m_hi), .lo(m_lo));

    assign req_ready = (state_q == IDLE && !rst) ? grant : '0;
    assign take      = |(req_valid & req_ready);

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        id_d    = id_q;
        a_d     = a_q;
        b_d     = b_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        case (state_q)
            IDLE: if (take) begin
                state_d = CALC;
                ptr_d   = (int'(pick_id) == NREQ - 1) ? '0 : pick_id + 1'b1;
                id_d    = pick_id;
                a_d     = req_a[MULT_W*int'(pick_id) +: MULT_W];
                b_d     = req_b[MULT_W*int'(pick_id) +: MULT_W];
            end
            CALC: begin
                state_d = RESP;
                hi_d    = m_hi;
                lo_d    = m_lo;
            end
            RESP: state_d = resp_ready ? IDLE : RESP;
            default: state_d = IDLE;
        endcase
        valid_d = state_d == RESP;
        busy_d  = state_d != IDLE;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            id_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            id_q    <= id_d;
            a_q     <= a_d;
            b_q     <= b_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            valid_q <= valid_d;
            busy_q  <= busy_d;
        end
    end

    assign resp_valid = valid_q;
    assign resp_id    = id_q;
    assign resp_hi    = hi_q;
    assign resp_lo    = lo_q;
    assign busy       = busy_q;
endmodule

// File: tb/tb_mult_arbiter.sv
// tb_mult_arbiter: scenario tasks plus randomized traffic against a round-robin reference model.
module tb_mult_arbiter;
    localparam int NREQ = 2;
    localparam int IDW  = 1;

    logic clk = 1'b0;
    logic rst;
    logic [NREQ-1:0] req_valid, req_ready;
    logic [16*NREQ-1:0] req_a, req_b;
    logic resp_valid, resp_ready, busy;
    logic [IDW-1:0] resp_id;
    logic [15:0] resp_hi, resp_lo;

    int n_cmp = 0;
    int n_bad = 0;
    int ptr_m = 0;

    always #5 clk = ~clk;

    mult_arbiter #(.NREQ(NREQ), .IDW(IDW)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b), .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_id(resp_id), .resp_hi(resp_hi), .resp_lo(resp_lo), .busy(busy)
    );

    function automatic int model_pick(input logic [NREQ-1:0] m);
        for (int k = 0; k < NREQ; k++)
            if (m[(ptr_m + k) % NREQ]) return (ptr_m + k) % NREQ;
        return -1;
    endfunction

    task automatic send(input int r, input logic [15:0] a, input logic [15:0] b);
        req_a[16*r +: 16] = a;
        req_b[16*r +: 16] = b;
        req_valid[r] = 1'b1;
    endtask

    task automatic wait_grant(output int id);
        id = -1;
        for (int c = 0; c < 20 && id < 0; c++) begin
            for (int i = 0; i < NREQ; i++) if (req_valid[i] && req_ready[i]) id = i;
            if (id < 0) begin @(negedge clk); #1; end
        end
    endtask

    task automatic accept(output int id);
        wait_grant(id);
        if (id >= 0) begin
            @(posedge clk);
            ptr_m = (id + 1) % NREQ;
            @(negedge clk);
            req_valid[id] = 1'b0;
            #1;
        end
    endtask

    task automatic wait_resp(output int lat);
        lat = 1;
        while (!resp_valid && lat < 20) begin @(negedge clk); #1; lat++; end
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        rst = 1'b1;
        #1;
        rst = 1'b0;
        ptr_m = 0;
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; req_valid = '1; resp_ready = 1'b1; req_a = '1; req_b = '1;
        repeat (3) @(negedge clk);
        #1;
        n_cmp++;
        if ({req_ready, resp_valid, busy, resp_id, resp_hi, resp_lo} !== '0) begin
            n_bad++;
            $display("FAIL reset_outputs: got rdy=%b v=%b busy=%b id=%h hi=%h lo=%h, expected all 0",
                     req_ready, resp_valid, busy, resp_id, resp_hi, resp_lo);
        end
        @(negedge clk);
        rst = 1'b0; req_valid = '0; ptr_m = 0;
        #1;
        n_cmp++;
        if ({resp_valid, busy} !== 2'b00) begin
            n_bad++; $display("FAIL reset_release: got v=%b busy=%b expected 0 0", resp_valid, busy);
        end
    endtask

    task automatic test_single_op(input string name, input int r, input logic [15:0] a, input logic [15:0] b);
        int id, lat, exp_id;
        logic [31:0] prod;
        prod = 32'(a) * 32'(b);
        req_valid = '0; resp_ready = 1'b1;
        send(r, a, b);
        #1;
        exp_id = model_pick(req_valid);
        accept(id);
        n_cmp++;
        if (id !== exp_id) begin n_bad++; $display("FAIL %s_grant: got %0d expected %0d", name, id, exp_id); end
        n_cmp++;
        if ({resp_valid, busy, req_ready} !== {2'b01, {NREQ{1'b0}}}) begin
            n_bad++; $display("FAIL %s_calc: got v=%b busy=%b rdy=%b expected 0 1 0", name, resp_valid, busy, req_ready);
        end
        wait_resp(lat);
        n_cmp++;
        if (lat != 2) begin n_bad++; $display("FAIL %s_latency: got %0d expected 2", name, lat); end
        n_cmp++;
        if ({resp_id, resp_hi, resp_lo} !== {IDW'(r), prod}) begin
            n_bad++; $display("FAIL %s_result: got id=%0d %h%h expected id=%0d %h", name, resp_id, resp_hi, resp_lo, r, prod);
        end
        @(negedge clk); #1;
        n_cmp++;
        if ({resp_valid, busy} !== 2'b00) begin
            n_bad++; $display("FAIL %s_release: got v=%b busy=%b expected 0 0", name, resp_valid, busy);
        end
    endtask

    task automatic test_backpressure();
        int id, lat;
        logic [31:0] prod, snap;
        logic [15:0] a, b;
        a = 16'($urandom); b = 16'($urandom);
        prod = 32'(a) * 32'(b);
        req_valid = '0; resp_ready = 1'b0;
        send(1, a, b);
        #1;
        accept(id);
        wait_resp(lat);
        snap = {resp_hi, resp_lo};
        n_cmp++;
        if ({resp_valid, resp_id, snap} !== {1'b1, IDW'(1), prod}) begin
            n_bad++; $display("FAIL bp_first: got v=%b id=%0d %h expected 1 1 %h", resp_valid, resp_id, snap, prod);
        end
        send(0, 16'($urandom), 16'($urandom));
        send(1, 16'($urandom), 16'($urandom));
        for (int k = 0; k < 5; k++) begin
            @(negedge clk); #1;
            n_cmp++;
            if ({resp_valid, resp_id, resp_hi, resp_lo, req_ready, busy} !== {1'b1, IDW'(1), prod, {NREQ{1'b0}}, 1'b1}) begin
                n_bad++;
                $display("FAIL bp_hold%0d: got v=%b id=%0d %h%h rdy=%b busy=%b expected 1 1 %h 0 1",
                         k, resp_valid, resp_id, resp_hi, resp_lo, req_ready, busy, prod);
            end
        end
        resp_ready = 1'b1;
        @(negedge clk); #1;
        n_cmp++;
        if ({resp_valid, busy, req_ready} !== {2'b00, NREQ'(1 << model_pick(req_valid))}) begin
            n_bad++; $display("FAIL bp_release: got v=%b busy=%b rdy=%b expected 0 0 %b",
                              resp_valid, busy, req_ready, NREQ'(1 << model_pick(req_valid)));
        end
        req_valid = '0;
        #1;
    endtask

    task automatic test_reset_mid_calc();
        int id, lat;
        req_valid = '0; resp_ready = 1'b1;
        send(0, 16'h1111, 16'h2222);
        #1;
        accept(id);
        rst = 1'b1;
        send(0, 16'h0007, 16'h0009);
        send(1, 16'h0005, 16'h0006);
        #1;
        n_cmp++;
        if ({req_ready, resp_valid, busy, resp_id, resp_hi, resp_lo} !== '0) begin
            n_bad++; $display("FAIL rstcalc_outputs: got rdy=%b v=%b busy=%b id=%h hi=%h lo=%h expected all 0",
                              req_ready, resp_valid, busy, resp_id, resp_hi, resp_lo);
        end
        ptr_m = 0;
        req_valid = '0;
        @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk); #1;
            n_cmp++;
            if (resp_valid !== 1'b0) begin n_bad++; $display("FAIL rstcalc_noresp%0d: got %b expected 0", k, resp_valid); end
        end
        req_valid = '1;
        #1;
        n_cmp++;
        if (req_ready !== NREQ'(1)) begin n_bad++; $display("FAIL rstcalc_ptr0: got rdy=%b expected 01", req_ready); end
        accept(id);
        req_valid = '0;
        wait_resp(lat);
        n_cmp++;
        if ({resp_id, resp_hi, resp_lo} !== {IDW'(0), 32'd63}) begin
            n_bad++; $display("FAIL rstcalc_result: got id=%0d %h%h expected id=0 0000003f", resp_id, resp_hi, resp_lo);
        end
        @(negedge clk); #1;
    endtask

    task automatic test_fairness();
        logic [31:0] prod [NREQ];
        int gid, exp_id, last, ngr, pend, lat;
        pulse_reset();
        resp_ready = 1'b1;
        for (int i = 0; i < NREQ; i++) begin
            logic [15:0] a, b;
            a = 16'($urandom); b = 16'($urandom);
            prod[i] = 32'(a) * 32'(b);
            send(i, a, b);
        end
        #1;
        last = -1; ngr = 0; pend = -1;
        for (int c = 0; c < 13; c++) begin
            gid = -1;
            for (int i = 0; i < NREQ; i++) if (req_valid[i] && req_ready[i]) gid = i;
            if (gid >= 0) begin
                exp_id = model_pick(req_valid);
                n_cmp++;
                if (gid != exp_id) begin n_bad++; $display("FAIL fair_order%0d: got %0d expected %0d", ngr, gid, exp_id); end
                if (last >= 0) begin
                    n_cmp++;
                    if (c - last != 3) begin n_bad++; $display("FAIL fair_spacing%0d: got %0d expected 3", ngr, c - last); end
                end
                last = c; ptr_m = (gid + 1) % NREQ; ngr++; pend = gid;
            end
            if (resp_valid) begin
                n_cmp++;
                if (pend < 0 || {resp_id, resp_hi, resp_lo} !== {IDW'(pend), prod[pend]}) begin
                    n_bad++; $display("FAIL fair_result: got id=%0d %h%h expected id=%0d", resp_id, resp_hi, resp_lo, pend);
                end
            end
            @(negedge clk); #1;
        end
        n_cmp++;
        if (ngr != 5) begin n_bad++; $display("FAIL fair_count: got %0d expected 5", ngr); end
        req_valid = '0;
        wait_resp(lat);
        @(negedge clk); #1;
    endtask

    task automatic test_random();
        logic [15:0] av [NREQ];
        logic [15:0] bv [NREQ];
        logic [NREQ-1:0] mask;
        logic [31:0] prod;
        int id, exp_id, lat, d;
        for (int t = 0; t < 20; t++) begin
            req_valid = '0; resp_ready = 1'b0;
            mask = NREQ'($urandom_range(1, (1 << NREQ) - 1));
            for (int i = 0; i < NREQ; i++) begin
                av[i] = ($urandom_range(0, 3) == 0) ? 16'hFFFF : 16'($urandom);
                bv[i] = ($urandom_range(0, 3) == 0) ? 16'h0000 : 16'($urandom);
                if (mask[i]) send(i, av[i], bv[i]);
            end
            #1;
            exp_id = model_pick(mask);
            accept(id);
            req_valid = '0;
            n_cmp++;
            if (id != exp_id) begin n_bad++; $display("FAIL rand%0d_grant: got %0d expected %0d", t, id, exp_id); end
            wait_resp(lat);
            n_cmp++;
            if (lat != 2) begin n_bad++; $display("FAIL rand%0d_latency: got %0d expected 2", t, lat); end
            prod = 32'(av[exp_id]) * 32'(bv[exp_id]);
            d = $urandom_range(0, 3);
            for (int k = 0; k < d; k++) begin @(negedge clk); #1; end
            n_cmp++;
            if ({resp_valid, resp_id, resp_hi, resp_lo} !== {1'b1, IDW'(exp_id), prod}) begin
                n_bad++; $display("FAIL rand%0d_result: got v=%b id=%0d %h%h expected 1 %0d %h",
                                  t, resp_valid, resp_id, resp_hi, resp_lo, exp_id, prod);
            end
            resp_ready = 1'b1;
            @(negedge clk); #1;
            n_cmp++;
            if (resp_valid !== 1'b0) begin n_bad++; $display("FAIL rand%0d_release: got %b expected 0", t, resp_valid); end
        end
    endtask

    initial begin
        test_reset();
        test_single_op("single", 0, 16'h0003, 16'h0005);
        test_single_op("max", 0, 16'hFFFF, 16'hFFFF);
        test_single_op("zero", 1, 16'h1234, 16'h0000);
        test_backpressure();
        test_reset_mid_calc();
        test_fairness();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
